// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator read-DMA slice:
// FSM encoding, AXI constants and the 4 KiB boundary size.
package accel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        FIN
    } dma_state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned BOUNDARY_4K    = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the channel after the
// last accepted one; the pointer only moves when the grant is accepted.
module rr_arbiter #(
    parameter  int unsigned NUM_CH    = 2,
    localparam int unsigned IDX_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_CH-1:0]    req,
    input  logic                 accept,
    output logic [NUM_CH-1:0]    grant,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    logic [IDX_WIDTH-1:0] last;

    always_comb begin
        logic                 found;
        logic [IDX_WIDTH-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = IDX_WIDTH'((32'(last) + i) % NUM_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Reset points at the last channel so channel 0 is searched first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last <= IDX_WIDTH'(NUM_CH - 1);
        end else if (accept && (|grant)) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/multi_ch_rd_dma.sv
// Multi-channel AXI4 read DMA: arbitrates channel requests, splits each into
// 4 KiB-safe INCR bursts (one outstanding) and streams beats to the owner.
module multi_ch_rd_dma
    import accel_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 256,
    parameter int unsigned          ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0]  ID_BASE    = 8'h80,
    parameter int unsigned          NUM_CH     = 2,
    parameter int unsigned          MAX_BURST  = 16,
    parameter int unsigned          LEN_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  req_beats,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic                         out_last,
    output logic [NUM_CH-1:0]            done,
    output logic [NUM_CH-1:0]            err,
    output logic [ID_WIDTH-1:0]          arid,
    output logic [ADDR_WIDTH-1:0]        araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [ID_WIDTH-1:0]          rid,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned SIZE     = $clog2(BYTES);
    localparam int unsigned BL_WIDTH = $clog2(MAX_BURST) + 1;
    localparam int unsigned CH_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned RW       = LEN_WIDTH + 1;

    // L = min(remaining, MAX_BURST, beats left before the next 4 KiB line)
    function automatic logic [BL_WIDTH-1:0] burst_len(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [LEN_WIDTH-1:0]  rem_in
    );
        logic [12:0] bnd;
        logic [RW-1:0] l;
        bnd = (13'(BOUNDARY_4K) - {1'b0, a[11:0]}) >> SIZE;
        l   = {1'b0, rem_in};
        if (l > RW'(MAX_BURST)) l = RW'(MAX_BURST);
        if (l > RW'(bnd))       l = RW'(bnd);
        return BL_WIDTH'(l);
    endfunction

    dma_state_t            state, nstate;
    logic [CH_WIDTH-1:0]   ch;
    logic [LEN_WIDTH-1:0]  rem;
    logic [BL_WIDTH-1:0]   cur_len;
    logic                  err_flag;

    logic [NUM_CH-1:0]     grant;
    logic [CH_WIDTH-1:0]   grant_idx;
    logic                  accept;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_beats;
    logic [BL_WIDTH-1:0]   first_len;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  rem_dec;
    logic [BL_WIDTH-1:0]   next_len;
    logic                  beat_hs;

    assign accept = (state == ARB);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_beats = req_beats[grant_idx*LEN_WIDTH +: LEN_WIDTH];
    assign first_len = burst_len(sel_addr, sel_beats);
    assign next_addr = araddr + (ADDR_WIDTH'(cur_len) << SIZE);
    assign rem_dec   = rem - LEN_WIDTH'(1);
    assign next_len  = burst_len(next_addr, rem_dec);
    assign beat_hs   = (state == DATA) && rvalid && rready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (|req_valid) nstate = ARB;
            ARB: begin
                if (!(|grant))              nstate = IDLE;
                else if (sel_beats == '0)   nstate = FIN;
                else                        nstate = ADDR;
            end
            ADDR: if (arready) nstate = DATA;
            DATA: begin
                if (beat_hs && rlast) nstate = (rem_dec == '0) ? FIN : ADDR;
            end
            FIN:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch       <= '0;
            rem      <= '0;
            cur_len  <= '0;
            err_flag <= 1'b0;
            araddr   <= '0;
            arlen    <= '0;
            arid     <= '0;
        end else begin
            unique case (state)
                ARB: begin
                    if (|grant) begin
                        ch       <= grant_idx;
                        rem      <= sel_beats;
                        araddr   <= sel_addr;
                        cur_len  <= first_len;
                        arlen    <= 8'(first_len) - 8'd1;
                        arid     <= ID_BASE + ID_WIDTH'(grant_idx);
                        err_flag <= 1'b0;
                    end
                end
                DATA: begin
                    if (beat_hs) begin
                        rem <= rem_dec;
                        if ((rresp != AXI_RESP_OKAY) || (rid != arid)) err_flag <= 1'b1;
                        // Next burst is sized from the advanced address and the post-beat count.
                        if (rlast && (rem_dec != '0)) begin
                            araddr  <= next_addr;
                            cur_len <= next_len;
                            arlen   <= 8'(next_len) - 8'd1;
                        end
                    end
                end
                FIN:     err_flag <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        out_valid = '0;
        out_last  = 1'b0;
        done      = '0;
        err       = '0;
        unique case (state)
            ARB:  req_ready = grant;
            ADDR: arvalid   = 1'b1;
            DATA: begin
                rready        = out_ready[ch];
                out_valid[ch] = rvalid;
                out_last      = rvalid && (rem == LEN_WIDTH'(1));
            end
            FIN: begin
                done[ch] = 1'b1;
                err[ch]  = err_flag;
            end
            default: ;
        endcase
    end

    assign out_data = rdata;
    assign arsize   = 3'(SIZE);
    assign arburst  = AXI_BURST_INCR;

endmodule

// File: tb/tb_multi_ch_rd_dma.sv
// Directed bench for multi_ch_rd_dma: vector table of single requests against
// a small AXI read slave, plus round-robin, stall and reset sequences.
module tb_multi_ch_rd_dma;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;
    localparam int unsigned IW = 8;
    localparam int unsigned NC = 2;
    localparam int unsigned LW = 16;

    logic            clk, rstn;
    logic [NC-1:0]   req_valid, req_ready;
    logic [NC*AW-1:0] req_addr;
    logic [NC*LW-1:0] req_beats;
    logic [DW-1:0]   out_data;
    logic [NC-1:0]   out_valid, out_ready, done, err;
    logic            out_last;
    logic [IW-1:0]   arid, rid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst, rresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   rdata;

    multi_ch_rd_dma #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ID_WIDTH (IW), .ID_BASE (8'h80),
        .NUM_CH (NC), .MAX_BURST (16), .LEN_WIDTH (LW)
    ) dut (
        .clk (clk), .rstn (rstn),
        .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr), .req_beats (req_beats),
        .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready), .out_last (out_last),
        .done (done), .err (err),
        .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize), .arburst (arburst),
        .arvalid (arvalid), .arready (arready),
        .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {8{a}};
    endfunction

    // ---------------- monitor ----------------
    int          cyc = 0;
    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [IW-1:0] ar_id_q[$];
    logic [DW-1:0] data_q[$];
    bit          last_q[$];
    int          grant_q[$];
    int          done_cnt = 0, grant_cyc = 0, done_cyc = 0;
    int          own_viol = 0, ar_viol = 0, err_lone = 0;
    logic [NC-1:0] done_vec = '0, err_vec = '0;

    initial begin
        logic [1:0] ov_exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn) begin
                if (arvalid && arready) begin
                    ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(arlen);
                    ar_id_q.push_back(arid);
                    if (arsize != 3'd5 || arburst != 2'b01 ||
                        (int'(araddr[11:0]) + (int'(arlen) + 1) * 32) > 4096)
                        ar_viol++;
                end
                if (out_valid != '0) begin
                    ov_exp = 2'b01 << (arid - 8'h80);
                    if (out_valid != ov_exp) own_viol++;
                end
                if (|(out_valid & out_ready)) begin
                    data_q.push_back(out_data);
                    last_q.push_back(out_last);
                end
                if (|req_ready) begin
                    grant_q.push_back(req_ready[1] ? 1 : 0);
                    grant_cyc = cyc;
                end
                if (|done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    done_vec = done;
                    err_vec  = err;
                end
                if ((err & ~done) != '0) err_lone++;
            end
        end
    end

    // ---------------- AXI read slave ----------------
    int          err_beat = -1;
    int          s_gbeat = 0;
    int          s_beat = 0, s_len = 0;
    logic [AW-1:0] s_addr;
    logic [IW-1:0] s_id;
    bit          s_active = 0;

    task automatic present();
        rvalid = 1'b1;
        rdata  = data_of(s_addr + AW'(s_beat * 32));
        rlast  = (s_beat == s_len);
        rid    = s_id;
        rresp  = (s_gbeat == err_beat) ? 2'b10 : 2'b00;
    endtask

    initial begin
        bit ar_hs, r_hs;
        logic [AW-1:0] cap_addr;
        logic [7:0]    cap_len;
        logic [IW-1:0] cap_id;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00; rid = '0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            cap_addr = araddr; cap_len = arlen; cap_id = arid;
            @(posedge clk);
            #1;
            if (!rstn) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; s_active = 0;
            end else begin
                if (r_hs) begin
                    s_gbeat++;
                    if (s_beat == s_len) begin
                        rvalid = 1'b0; rlast = 1'b0; s_active = 0;
                    end else begin
                        s_beat++;
                        present();
                    end
                end
                if (ar_hs) begin
                    arready  = 1'b0;
                    s_addr   = cap_addr;
                    s_len    = int'(cap_len);
                    s_id     = cap_id;
                    s_beat   = 0;
                    s_active = 1;
                    present();
                end else if (arvalid && !s_active && !arready) begin
                    arready = 1'b1;
                end
            end
        end
    end

    // ---------------- request helpers ----------------
    task automatic do_req(input int unsigned ch, input logic [AW-1:0] addr,
                          input int unsigned beats, output bit ok);
        bit got;
        int d0;
        got = 0;
        d0  = done_cnt;
        req_addr[ch*AW +: AW]  = addr;
        req_beats[ch*LW +: LW] = beats[LW-1:0];
        req_valid[ch] = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req_ready[ch]) got = 1;
        end
        @(posedge clk);
        #1;
        req_valid[ch] = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        ok = got && (done_cnt != d0);
    endtask

    task automatic stall_seq();
        for (int i = 0; i < 500 && data_q.size() < 4; i++) @(negedge clk);
        chk("stall_wait", 64'(data_q.size() >= 4), 64'd1);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rready", 64'(rready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
    endtask

    task automatic clear_logs();
        ar_addr_q.delete(); ar_len_q.delete(); ar_id_q.delete();
        data_q.delete(); last_q.delete(); grant_q.delete();
    endtask

    typedef struct {
        int unsigned ch;
        logic [AW-1:0] addr;
        int unsigned beats;
        int          err_beat;
        bit          stall;
        int unsigned exp_nar;
        logic [7:0]  exp_len0;
        logic [7:0]  exp_len_last;
        logic [AW-1:0] exp_addr_last;
        logic        exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d0, bad, nlast;
        int exp_g[4];

        vecs[0] = '{0, 32'h0000_1000, 40, -1, 0, 3, 8'd15, 8'd7, 32'h0000_1400, 1'b0};
        vecs[1] = '{1, 32'h0000_0FC0,  8, -1, 0, 2, 8'd1,  8'd5, 32'h0000_1000, 1'b0};
        vecs[2] = '{0, 32'h0000_2000,  4,  2, 0, 1, 8'd3,  8'd3, 32'h0000_2000, 1'b1};
        vecs[3] = '{0, 32'h0000_3000,  4, -1, 0, 1, 8'd3,  8'd3, 32'h0000_3000, 1'b0};
        vecs[4] = '{1, 32'h0000_0000,  0, -1, 0, 0, 8'd0,  8'd0, 32'h0000_0000, 1'b0};
        vecs[5] = '{1, 32'h0000_5FE0,  3, -1, 0, 2, 8'd0,  8'd1, 32'h0000_6000, 1'b0};
        vecs[6] = '{0, 32'h0000_7000, 16, -1, 1, 1, 8'd15, 8'd15, 32'h0000_7000, 1'b0};
        exp_g = '{0, 1, 0, 1};

        rstn = 1'b0; req_valid = '0; req_addr = '0; req_beats = '0; out_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 64'({arvalid, rready, req_ready, out_valid, out_last, done, err}), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_arid", 64'(arid), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // round robin: both channels request, twice each
        clear_logs();
        begin
            int c0, c1, dstart;
            c0 = 0; c1 = 0; dstart = done_cnt;
            req_addr  = {32'h0000_9000, 32'h0000_8000};
            req_beats = {16'd2, 16'd2};
            req_valid = 2'b11;
            for (int i = 0; i < 3000 && (done_cnt - dstart) < 4; i++) begin
                @(negedge clk);
                if (req_ready[0]) c0++;
                if (req_ready[1]) c1++;
                @(posedge clk);
                #1;
                if (c0 >= 2) req_valid[0] = 1'b0;
                if (c1 >= 2) req_valid[1] = 1'b0;
            end
            req_valid = '0;
            chk("rr_done_count", 64'(done_cnt - dstart), 64'd4);
            chk("rr_grant_count", 64'(grant_q.size()), 64'd4);
            for (int i = 0; i < 4; i++)
                if (i < grant_q.size()) chk($sformatf("rr_grant%0d", i), 64'(grant_q[i]), 64'(exp_g[i]));
            chk("rr_beats", 64'(data_q.size()), 64'd8);
        end

        for (int v = 0; v < NV; v++) begin
            clear_logs();
            s_gbeat  = 0;
            err_beat = vecs[v].err_beat;
            d0 = done_cnt;
            if (vecs[v].stall) begin
                fork
                    do_req(vecs[v].ch, vecs[v].addr, vecs[v].beats, ok);
                    stall_seq();
                join
            end else begin
                do_req(vecs[v].ch, vecs[v].addr, vecs[v].beats, ok);
            end
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_handshake", v), 64'(ok), 64'd1);
            chk($sformatf("v%0d_ar_count", v), 64'(ar_addr_q.size()), 64'(vecs[v].exp_nar));
            if (vecs[v].exp_nar > 0 && ar_addr_q.size() > 0) begin
                chk($sformatf("v%0d_ar_addr0", v), 64'(ar_addr_q[0]), 64'(vecs[v].addr));
                chk($sformatf("v%0d_arlen0", v), 64'(ar_len_q[0]), 64'(vecs[v].exp_len0));
                chk($sformatf("v%0d_arlen_last", v), 64'(ar_len_q[$]), 64'(vecs[v].exp_len_last));
                chk($sformatf("v%0d_araddr_last", v), 64'(ar_addr_q[$]), 64'(vecs[v].exp_addr_last));
                chk($sformatf("v%0d_arid", v), 64'(ar_id_q[0]), 64'(8'h80 + vecs[v].ch));
            end
            chk($sformatf("v%0d_beats", v), 64'(data_q.size()), 64'(vecs[v].beats));
            bad = 0; nlast = 0;
            for (int k = 0; k < data_q.size(); k++) begin
                if (data_q[k] !== data_of(vecs[v].addr + AW'(k * 32))) bad++;
                if (last_q[k]) nlast++;
            end
            chk($sformatf("v%0d_data_order", v), 64'(bad), 64'd0);
            chk($sformatf("v%0d_out_last_cnt", v), 64'(nlast), 64'(vecs[v].beats > 0 ? 1 : 0));
            if (vecs[v].beats > 0 && last_q.size() == vecs[v].beats)
                chk($sformatf("v%0d_out_last_pos", v), 64'(last_q[vecs[v].beats-1]), 64'd1);
            chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt - d0), 64'd1);
            chk($sformatf("v%0d_done_vec", v), 64'(done_vec), 64'(2'b01 << vecs[v].ch));
            chk($sformatf("v%0d_err_vec", v), 64'(err_vec), 64'(vecs[v].exp_err ? (2'b01 << vecs[v].ch) : 2'b00));
            if (vecs[v].beats == 0)
                chk($sformatf("v%0d_done_latency", v), 64'(done_cyc - grant_cyc), 64'd1);
        end

        // reset in the middle of a DATA phase
        clear_logs();
        s_gbeat = 0; err_beat = -1;
        begin
            bit got;
            got = 0;
            req_addr[AW-1:0] = 32'h0000_A000;
            req_beats[LW-1:0] = 16'd16;
            req_valid[0] = 1'b1;
            for (int i = 0; i < 300 && !got; i++) begin
                @(negedge clk);
                if (req_ready[0]) got = 1;
            end
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            for (int i = 0; i < 500 && data_q.size() < 3; i++) @(negedge clk);
            chk("rstdata_reached", 64'(data_q.size() >= 3), 64'd1);
            @(posedge clk);
            #1;
            d0 = done_cnt;
            rstn = 1'b0;
            #1;
            chk("rstdata_outputs", 64'({arvalid, rready, req_ready, out_valid, out_last, done, err}), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            rstn = 1'b1;
            repeat (10) @(negedge clk);
            chk("rstdata_no_done", 64'(done_cnt - d0), 64'd0);
        end

        chk("owner_violations", 64'(own_viol), 64'd0);
        chk("ar_violations", 64'(ar_viol), 64'd0);
        chk("err_without_done", 64'(err_lone), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
